// File: rtl/s_term_loopback_cfg_pkg.sv
// Shared definitions for the southern-edge loopback terminal: group modes,
// configuration layout and the test-pattern LFSR.
package s_term_loopback_cfg_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_REG  = 2'b01,
        MODE_TIE  = 2'b10,
        MODE_TEST = 2'b11
    } mode_e;

    localparam int CFG_BITS = 6;

    localparam int GRP1_OFS = 0;
    localparam int GRP2_OFS = 2;
    localparam int GRP4_OFS = 4;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/s_term_loopback_cfg_if.sv
// South-bound ends and north-bound loopback wires of one terminal tile.
interface s_term_loopback_cfg_if #(
    parameter int W1 = 4,
    parameter int W2 = 8,
    parameter int W4 = 16
);
    logic [W1-1:0] S1END;
    logic [W2-1:0] S2MID;
    logic [W2-1:0] S2END;
    logic [W4-1:0] S4END;
    logic [W1-1:0] N1BEG;
    logic [W2-1:0] N2BEG;
    logic [W2-1:0] N2BEGb;
    logic [W4-1:0] N4BEG;

    modport master (
        output S1END, S2MID, S2END, S4END,
        input  N1BEG, N2BEG, N2BEGb, N4BEG
    );

    modport slave (
        input  S1END, S2MID, S2END, S4END,
        output N1BEG, N2BEG, N2BEGb, N4BEG
    );
endinterface

// File: rtl/s_term_loopback_cfg_term_group_path.sv
// One wire group: index reversal, a free-running pipeline and the mode mux.
module term_group_path
    import s_term_loopback_cfg_pkg::*;
#(
    parameter int W          = 4,
    parameter int PIPE_DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_in,
    input  mode_e        i_mode,
    input  logic [W-1:0] i_test,
    output logic [W-1:0] o_out
);

    logic [W-1:0] w_rev;
    logic [W-1:0] r_pipe [PIPE_DEPTH];

    for (genvar g = 0; g < W; g++) begin : g_rev
        assign w_rev[g] = i_in[W-1-g];
    end

    // The pipeline clocks in every mode so REG has valid history the moment it is selected.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= w_rev;
            for (int k = 1; k < PIPE_DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    always_comb begin
        o_out = '0;
        unique case (i_mode)
            MODE_PASS: o_out = w_rev;
            MODE_REG:  o_out = r_pipe[PIPE_DEPTH-1];
            MODE_TIE:  o_out = '0;
            MODE_TEST: o_out = i_test;
        endcase
    end

endmodule

// File: rtl/s_term_loopback_cfg.sv
// Southern-edge terminal: loops S-bound wires back north per group, with a
// serially loaded, atomically committed mode word and an LFSR test source.
module s_term_loopback_cfg
    import s_term_loopback_cfg_pkg::*;
#(
    parameter int          W1         = 4,
    parameter int          W2         = 8,
    parameter int          W4         = 16,
    parameter int          PIPE_DEPTH = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  UserCLK,
    input  logic                  RST,
    s_term_loopback_cfg_if.slave  io_wires,
    input  logic                  cfg_shift_en,
    input  logic                  cfg_data_in,
    input  logic                  cfg_load,
    output logic                  cfg_data_out
);

    localparam logic [15:0] SEED = lfsr_seed_fix(LFSR_SEED);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [15:0]         r_lfsr;

    mode_e         w_mode1;
    mode_e         w_mode2;
    mode_e         w_mode4;
    logic          w_any_test;
    logic [W1-1:0] w_tst1;
    logic [W2-1:0] w_tst2;
    logic [W2-1:0] w_tst2b;
    logic [W4-1:0] w_tst4;

    assign w_mode1    = mode_e'(r_active[GRP1_OFS +: 2]);
    assign w_mode2    = mode_e'(r_active[GRP2_OFS +: 2]);
    assign w_mode4    = mode_e'(r_active[GRP4_OFS +: 2]);
    assign w_any_test = (w_mode1 == MODE_TEST) || (w_mode2 == MODE_TEST) ||
                        (w_mode4 == MODE_TEST);

    // Shift and load may share an edge; load then commits the pre-shift shadow.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_shadow <= '0;
            r_active <= '0;
            r_lfsr   <= SEED;
        end else begin
            if (cfg_shift_en) r_shadow <= {r_shadow[CFG_BITS-2:0], cfg_data_in};
            if (cfg_load)     r_active <= r_shadow;
            if (w_any_test)   r_lfsr   <= lfsr_next(r_lfsr);
        end
    end

    assign cfg_data_out = r_shadow[CFG_BITS-1];

    for (genvar g = 0; g < W1; g++) begin : g_tst1
        assign w_tst1[g] = r_lfsr[g % 16];
    end
    // The N2BEGb pattern is offset by half the LFSR so the two buses differ.
    for (genvar g = 0; g < W2; g++) begin : g_tst2
        assign w_tst2[g]  = r_lfsr[g % 16];
        assign w_tst2b[g] = r_lfsr[(8 + g) % 16];
    end
    for (genvar g = 0; g < W4; g++) begin : g_tst4
        assign w_tst4[g] = r_lfsr[g % 16];
    end

    term_group_path #(.W(W1), .PIPE_DEPTH(PIPE_DEPTH)) u_grp1 (
        .i_clk (UserCLK),
        .i_rst (RST),
        .i_in  (io_wires.S1END),
        .i_mode(w_mode1),
        .i_test(w_tst1),
        .o_out (io_wires.N1BEG)
    );

    term_group_path #(.W(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_grp2_mid (
        .i_clk (UserCLK),
        .i_rst (RST),
        .i_in  (io_wires.S2MID),
        .i_mode(w_mode2),
        .i_test(w_tst2),
        .o_out (io_wires.N2BEG)
    );

    term_group_path #(.W(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_grp2_end (
        .i_clk (UserCLK),
        .i_rst (RST),
        .i_in  (io_wires.S2END),
        .i_mode(w_mode2),
        .i_test(w_tst2b),
        .o_out (io_wires.N2BEGb)
    );

    term_group_path #(.W(W4), .PIPE_DEPTH(PIPE_DEPTH)) u_grp4 (
        .i_clk (UserCLK),
        .i_rst (RST),
        .i_in  (io_wires.S4END),
        .i_mode(w_mode4),
        .i_test(w_tst4),
        .o_out (io_wires.N4BEG)
    );

endmodule

// File: tb/tb_s_term_loopback_cfg.sv
// Directed bench for s_term_loopback_cfg with PIPE_DEPTH=2 and the default seed.
module tb_s_term_loopback_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_shift_en = 1'b0;
    logic cfg_data_in  = 1'b0;
    logic cfg_load     = 1'b0;
    logic cfg_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    s_term_loopback_cfg_if #(.W1(4), .W2(8), .W4(16)) bus ();

    s_term_loopback_cfg #(
        .W1(4), .W2(8), .W4(16), .PIPE_DEPTH(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .UserCLK     (clk),
        .RST         (rst),
        .io_wires    (bus),
        .cfg_shift_en(cfg_shift_en),
        .cfg_data_in (cfg_data_in),
        .cfg_load    (cfg_load),
        .cfg_data_out(cfg_data_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic shift6(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) begin
            cfg_shift_en = 1'b1;
            cfg_data_in  = v[i];
            tick();
        end
        cfg_shift_en = 1'b0;
        cfg_data_in  = 1'b0;
    endtask

    task automatic do_load;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.S4END = 16'h0001; bus.S1END = 4'b0011; bus.S2MID = 8'h01; bus.S2END = 8'h0F;
        #1;
        checks++; if (bus.N4BEG !== 16'h8000) begin errors++; $display("FAIL rst_n4 got=%h exp=8000", bus.N4BEG); end
        checks++; if (bus.N1BEG !== 4'b1100) begin errors++; $display("FAIL rst_n1 got=%b exp=1100", bus.N1BEG); end
        checks++; if (bus.N2BEG !== 8'h80) begin errors++; $display("FAIL rst_n2 got=%h exp=80", bus.N2BEG); end
        checks++; if (bus.N2BEGb !== 8'hF0) begin errors++; $display("FAIL rst_n2b got=%h exp=f0", bus.N2BEGb); end
        checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL rst_dout got=%b exp=0", cfg_data_out); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.N4BEG !== 16'h8000) begin errors++; $display("FAIL post_rst_n4 got=%h exp=8000", bus.N4BEG); end
    endtask

    task automatic test_reg_mode;
        do_reset();
        bus.S4END = 16'h0000; bus.S1END = 4'b0110;
        shift6(6'b010000);
        do_load();
        checks++; if (bus.N4BEG !== 16'h0000) begin errors++; $display("FAIL reg_hist got=%h exp=0000", bus.N4BEG); end
        bus.S4END = 16'hFFFF;
        #1;
        checks++; if (bus.N4BEG !== 16'h0000) begin errors++; $display("FAIL reg_e0 got=%h exp=0000", bus.N4BEG); end
        tick();
        checks++; if (bus.N4BEG !== 16'h0000) begin errors++; $display("FAIL reg_e1 got=%h exp=0000", bus.N4BEG); end
        tick();
        checks++; if (bus.N4BEG !== 16'hFFFF) begin errors++; $display("FAIL reg_e2 got=%h exp=ffff", bus.N4BEG); end
        bus.S1END = 4'b0001; bus.S2END = 8'h03;
        #1;
        checks++; if (bus.N1BEG !== 4'b1000) begin errors++; $display("FAIL reg_g1_pass got=%b exp=1000", bus.N1BEG); end
        checks++; if (bus.N2BEGb !== 8'hC0) begin errors++; $display("FAIL reg_g2_pass got=%h exp=c0", bus.N2BEGb); end
    endtask

    task automatic test_lfsr;
        logic [15:0] m;
        do_reset();
        shift6(6'b111111);
        do_load();
        m = 16'hACE1;
        checks++; if (bus.N4BEG !== 16'hACE1) begin errors++; $display("FAIL lfsr_first got=%h exp=ace1", bus.N4BEG); end
        checks++; if (bus.N2BEGb !== 8'hAC) begin errors++; $display("FAIL lfsr_first_b got=%h exp=ac", bus.N2BEGb); end
        for (int i = 0; i < 32; i++) begin
            bus.S4END = 16'($urandom); bus.S1END = 4'($urandom);
            tick();
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
            if (i == 0) begin
                checks++; if (bus.N4BEG !== 16'h59C3) begin errors++; $display("FAIL lfsr_step1 got=%h exp=59c3", bus.N4BEG); end
            end
            checks++;
            if ({bus.N4BEG, bus.N2BEGb, bus.N2BEG, bus.N1BEG} !== {m, m[15:8], m[7:0], m[3:0]}) begin
                errors++;
                $display("FAIL lfsr_seq[%0d] got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
                         bus.N4BEG, bus.N2BEGb, bus.N2BEG, bus.N1BEG, m, m[15:8], m[7:0], m[3:0]);
            end
        end
    endtask

    task automatic test_tie;
        logic [5:0] m_sh;
        logic       b;
        shift6(6'b101010);
        do_load();
        m_sh = 6'b101010;
        checks++; if ({bus.N1BEG, bus.N2BEG, bus.N2BEGb, bus.N4BEG} !== 36'h0) begin errors++; $display("FAIL tie_first got=%h exp=0", {bus.N1BEG, bus.N2BEG, bus.N2BEGb, bus.N4BEG}); end
        for (int i = 0; i < 100; i++) begin
            b = 1'($urandom);
            bus.S1END = 4'($urandom); bus.S2MID = 8'($urandom);
            bus.S2END = 8'($urandom); bus.S4END = 16'($urandom);
            cfg_shift_en = 1'b1; cfg_data_in = b;
            tick();
            m_sh = {m_sh[4:0], b};
            checks++; if ({bus.N1BEG, bus.N2BEG, bus.N2BEGb, bus.N4BEG} !== 36'h0) begin errors++; $display("FAIL tie[%0d] got=%h exp=0", i, {bus.N1BEG, bus.N2BEG, bus.N2BEGb, bus.N4BEG}); end
            checks++; if (cfg_data_out !== m_sh[5]) begin errors++; $display("FAIL chain[%0d] got=%b exp=%b", i, cfg_data_out, m_sh[5]); end
        end
        cfg_shift_en = 1'b0; cfg_data_in = 1'b0;
    endtask

    task automatic test_same_edge;
        logic [4:0] exp_seq;
        do_reset();
        bus.S1END = 4'b0001; bus.S4END = 16'h1234; bus.S2MID = 8'h12;
        shift6(6'b000001);
        cfg_shift_en = 1'b1; cfg_data_in = 1'b1; cfg_load = 1'b1;
        tick();
        cfg_shift_en = 1'b0; cfg_data_in = 1'b0; cfg_load = 1'b0;
        checks++; if (bus.N1BEG !== 4'b1000) begin errors++; $display("FAIL se_reg_hist got=%b exp=1000", bus.N1BEG); end
        bus.S1END = 4'b0000;
        #1;
        checks++; if (bus.N1BEG !== 4'b1000) begin errors++; $display("FAIL se_reg_e0 got=%b exp=1000", bus.N1BEG); end
        tick();
        checks++; if (bus.N1BEG !== 4'b1000) begin errors++; $display("FAIL se_reg_e1 got=%b exp=1000", bus.N1BEG); end
        tick();
        checks++; if (bus.N1BEG !== 4'b0000) begin errors++; $display("FAIL se_reg_e2 got=%b exp=0000", bus.N1BEG); end
        checks++; if (bus.N4BEG !== 16'h2C48) begin errors++; $display("FAIL se_g4_pass got=%h exp=2c48", bus.N4BEG); end
        checks++; if (bus.N2BEG !== 8'h48) begin errors++; $display("FAIL se_g2_pass got=%h exp=48", bus.N2BEG); end
        checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL se_sh5 got=%b exp=0", cfg_data_out); end
        exp_seq = 5'b00011;
        for (int k = 1; k <= 5; k++) begin
            cfg_shift_en = 1'b1; cfg_data_in = 1'b0;
            tick();
            checks++; if (cfg_data_out !== exp_seq[5-k]) begin errors++; $display("FAIL se_shadow[%0d] got=%b exp=%b", k, cfg_data_out, exp_seq[5-k]); end
        end
        cfg_shift_en = 1'b0;
    endtask

    task automatic test_async_rst;
        do_reset();
        bus.S4END = 16'h0001; bus.S1END = 4'b0011; bus.S2MID = 8'h01; bus.S2END = 8'h0F;
        shift6(6'b011111);
        do_load();
        cfg_shift_en = 1'b1; cfg_data_in = 1'b1;
        tick();
        cfg_shift_en = 1'b0; cfg_data_in = 1'b0;
        tick();
        checks++; if (cfg_data_out !== 1'b1) begin errors++; $display("FAIL ar_pre_dout got=%b exp=1", cfg_data_out); end
        bus.S4END = 16'h0003;
        #1;
        checks++; if (bus.N4BEG !== 16'h8000) begin errors++; $display("FAIL ar_pre_reg got=%h exp=8000", bus.N4BEG); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.N4BEG !== 16'hC000) begin errors++; $display("FAIL ar_n4 got=%h exp=c000", bus.N4BEG); end
        checks++; if (bus.N1BEG !== 4'b1100) begin errors++; $display("FAIL ar_n1 got=%b exp=1100", bus.N1BEG); end
        checks++; if (bus.N2BEG !== 8'h80) begin errors++; $display("FAIL ar_n2 got=%h exp=80", bus.N2BEG); end
        checks++; if (bus.N2BEGb !== 8'hF0) begin errors++; $display("FAIL ar_n2b got=%h exp=f0", bus.N2BEGb); end
        tick();
        rst = 1'b0;
        checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL ar_shadow got=%b exp=0", cfg_data_out); end
        do_load();
        checks++; if (bus.N4BEG !== 16'hC000) begin errors++; $display("FAIL ar_load_zero got=%h exp=c000", bus.N4BEG); end
        shift6(6'b111111);
        do_load();
        checks++; if (bus.N4BEG !== 16'hACE1) begin errors++; $display("FAIL ar_seed got=%h exp=ace1", bus.N4BEG); end
    endtask

    initial begin
        test_reset();
        test_reg_mode();
        test_lfsr();
        test_tie();
        test_same_edge();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
